// File: rtl/pkt_edit_mch.sv
// -----------------------------------------------------------------------------
// pkt_edit_mch
//   Multi-channel, command-driven packet editor. Each accepted edit command
//   selects one of NCH input packet channels and edits exactly one packet from
//   it: pass, drop, strip leading beats, or strip and prepend a header beat.
//   Sits after the PD/command pre-edit stage and feeds the packet memory writer.
//
// Optional feature macro: PKT_EDIT_MCH_STAT_EN
//   Defined     : stat_pkt_cnt / stat_drp_cnt are live 32-bit wrapping counters.
//   Not defined : both stat ports are tied to 0 and no counter flops exist.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   cmd_vld/rdy   edit command handshake; rdy only while IDLE
//   cmd_dat       {hdr[ECMWID-1:18], tag[17:10], ch[9:6], strip_n[5:2], act[1:0]}
//   in_pkt_vld    per-channel beat valid
//   in_pkt_rdy    per-channel beat ready, at most one bit set
//   in_pkt_dat    channel c at [c*DAT_WID +: DAT_WID]
//   in_pkt_msg    channel c at [c*MSG_WID +: MSG_WID], bit EOP_POS = end of packet
//   out_pkt_*     registered output beat: vld/rdy, dat,
//                 msg = {tag[7:0], beat_idx[11:0], ch[3:0], msg[MSG_WID-1:0]}
//   cmd_err       1-cycle pulse when a command with ch >= NCH is discarded
//   stat_pkt_cnt  packets emitted (EOP beats loaded into the output register)
//   stat_drp_cnt  packets fully discarded (act 01, or act 10 stripped to nothing)
// -----------------------------------------------------------------------------
module pkt_edit_mch #(
    parameter  int DAT_WID  = 256,
    parameter  int MSG_WID  = 14,
    parameter  int EOP_POS  = 1,
    parameter  int NCH      = 4,
    parameter  int ECMWID   = 92,
    localparam int OMSG_WID = MSG_WID + 24
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_vld,
    output logic                    cmd_rdy,
    input  logic [ECMWID-1:0]       cmd_dat,

    input  logic [NCH-1:0]          in_pkt_vld,
    output logic [NCH-1:0]          in_pkt_rdy,
    input  logic [NCH*DAT_WID-1:0]  in_pkt_dat,
    input  logic [NCH*MSG_WID-1:0]  in_pkt_msg,

    output logic                    out_pkt_vld,
    input  logic                    out_pkt_rdy,
    output logic [DAT_WID-1:0]      out_pkt_dat,
    output logic [OMSG_WID-1:0]     out_pkt_msg,

    output logic                    cmd_err,
    output logic [31:0]             stat_pkt_cnt,
    output logic [31:0]             stat_drp_cnt
);

    localparam int HDR_WID = ECMWID - 18;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_STRIP = 3'd1;
    localparam logic [2:0] S_DROP  = 3'd2;
    localparam logic [2:0] S_HDR   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;

    // NCH can be 16, so the channel-range compare is done one bit wider.
    localparam logic [4:0] NCH_LIM = 5'(NCH);

    // ------------------------------------------------------------------
    // Command fields
    // ------------------------------------------------------------------
    logic [HDR_WID-1:0] cmd_hdr;
    logic [7:0]         cmd_tag;
    logic [3:0]         cmd_ch;
    logic [3:0]         cmd_strip;
    logic [1:0]         cmd_act;

    assign cmd_hdr   = cmd_dat[ECMWID-1:18];
    assign cmd_tag   = cmd_dat[17:10];
    assign cmd_ch    = cmd_dat[9:6];
    assign cmd_strip = cmd_dat[5:2];
    assign cmd_act   = cmd_dat[1:0];

    // ------------------------------------------------------------------
    // State and latched command
    // ------------------------------------------------------------------
    logic [2:0]         state;
    logic [HDR_WID-1:0] hdr_q;
    logic [7:0]         tag_q;
    logic [3:0]         ch_q;
    logic [3:0]         strip_q;     // beats still to strip
    logic [1:0]         act_q;
    logic               hdr_eop_q;   // packet ended while stripping: header carries EOP
    logic [11:0]        beat_idx;

    logic               cmd_acc;
    logic               cmd_bad;
    logic               out_free;
    logic               beat_rdy;
    logic               beat_acc;
    logic               load_hdr;
    logic               load_dat;

    logic [DAT_WID-1:0] sel_dat;
    logic [MSG_WID-1:0] sel_msg;
    logic               sel_vld;
    logic               sel_eop;
    logic [MSG_WID-1:0] hdr_msg;

    // ------------------------------------------------------------------
    // Channel select
    // ------------------------------------------------------------------
    always_comb begin
        sel_dat = '0;
        sel_msg = '0;
        sel_vld = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (ch_q == 4'(c)) begin
                sel_dat = in_pkt_dat[c*DAT_WID +: DAT_WID];
                sel_msg = in_pkt_msg[c*MSG_WID +: MSG_WID];
                sel_vld = in_pkt_vld[c];
            end
        end
    end

    assign sel_eop = sel_msg[EOP_POS];

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign cmd_rdy  = (state == S_IDLE) & ~rst;
    assign cmd_acc  = cmd_vld & cmd_rdy;
    assign cmd_bad  = {1'b0, cmd_ch} >= NCH_LIM;
    assign out_free = ~out_pkt_vld | out_pkt_rdy;

    // Stripped/dropped beats never touch the output register, so they are
    // taken unconditionally; pass-through beats wait for a free output slot.
    always_comb begin
        beat_rdy = 1'b0;
        if (!rst) begin
            case (state)
                S_STRIP, S_DROP: beat_rdy = 1'b1;
                S_DATA:          beat_rdy = out_free;
                default:         beat_rdy = 1'b0;
            endcase
        end
    end

    always_comb begin
        in_pkt_rdy = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            in_pkt_rdy[c] = beat_rdy & (ch_q == 4'(c));
        end
    end

    assign beat_acc = beat_rdy & sel_vld;
    assign load_hdr = (state == S_HDR) & out_free;
    assign load_dat = (state == S_DATA) & beat_acc;

    always_comb begin
        hdr_msg          = '0;
        hdr_msg[EOP_POS] = hdr_eop_q;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hdr_q     <= '0;
            tag_q     <= '0;
            ch_q      <= '0;
            strip_q   <= '0;
            act_q     <= '0;
            hdr_eop_q <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_acc) begin
                        if (cmd_bad) begin
                            cmd_err <= 1'b1;
                        end else begin
                            hdr_q     <= cmd_hdr;
                            tag_q     <= cmd_tag;
                            ch_q      <= cmd_ch;
                            strip_q   <= cmd_strip;
                            act_q     <= cmd_act;
                            hdr_eop_q <= 1'b0;
                            if (cmd_act[1] && (cmd_strip != 4'd0))
                                state <= S_STRIP;
                            else if (cmd_act == 2'b01)
                                state <= S_DROP;
                            else if (cmd_act == 2'b11)
                                state <= S_HDR;
                            else
                                state <= S_DATA;
                        end
                    end
                end
                S_STRIP: begin
                    if (beat_acc) begin
                        if (sel_eop) begin
                            // Packet exhausted before stripping finished.
                            if (act_q[0]) begin
                                hdr_eop_q <= 1'b1;
                                state     <= S_HDR;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            strip_q <= strip_q - 4'd1;
                            if (strip_q == 4'd1)
                                state <= act_q[0] ? S_HDR : S_DATA;
                        end
                    end
                end
                S_DROP: begin
                    if (beat_acc && sel_eop)
                        state <= S_IDLE;
                end
                S_HDR: begin
                    if (out_free)
                        state <= hdr_eop_q ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (beat_acc && sel_eop)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output beat index (saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx <= '0;
        end else if (cmd_acc) begin
            beat_idx <= '0;
        end else if ((load_hdr || load_dat) && (beat_idx != 12'hfff)) begin
            beat_idx <= beat_idx + 12'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pkt_vld <= 1'b0;
            out_pkt_dat <= '0;
            out_pkt_msg <= '0;
        end else if (load_hdr) begin
            out_pkt_vld <= 1'b1;
            out_pkt_dat <= DAT_WID'(hdr_q);
            out_pkt_msg <= {tag_q, beat_idx, ch_q, hdr_msg};
        end else if (load_dat) begin
            out_pkt_vld <= 1'b1;
            out_pkt_dat <= sel_dat;
            out_pkt_msg <= {tag_q, beat_idx, ch_q, sel_msg};
        end else if (out_pkt_rdy) begin
            out_pkt_vld <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef PKT_EDIT_MCH_STAT_EN
    logic        pkt_done;
    logic        drp_done;
    logic [31:0] pkt_cnt_q;
    logic [31:0] drp_cnt_q;

    assign pkt_done = (load_dat & sel_eop) | (load_hdr & hdr_eop_q);
    assign drp_done = beat_acc & sel_eop &
                      ((state == S_DROP) | ((state == S_STRIP) & (act_q == 2'b10)));

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            drp_cnt_q <= '0;
        end else begin
            if (pkt_done) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (drp_done) drp_cnt_q <= drp_cnt_q + 32'd1;
        end
    end

    assign stat_pkt_cnt = pkt_cnt_q;
    assign stat_drp_cnt = drp_cnt_q;
`else
    assign stat_pkt_cnt = '0;
    assign stat_drp_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_edit_mch.sv
// -----------------------------------------------------------------------------
// tb_pkt_edit_mch
//   Directed bench for pkt_edit_mch (NCH=4, DAT_WID=256, MSG_WID=14).
//   Non-selected channels always offer junk beats (all ones, EOP set) so that
//   a wrong channel select shows up in the output stream.
// -----------------------------------------------------------------------------
module tb_pkt_edit_mch;

    localparam int DAT_WID  = 256;
    localparam int MSG_WID  = 14;
    localparam int EOP_POS  = 1;
    localparam int NCH      = 4;
    localparam int ECMWID   = 92;
    localparam int OMSG_WID = MSG_WID + 24;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_vld;
    logic                   cmd_rdy;
    logic [ECMWID-1:0]      cmd_dat;
    logic [NCH-1:0]         in_pkt_vld;
    logic [NCH-1:0]         in_pkt_rdy;
    logic [NCH*DAT_WID-1:0] in_pkt_dat;
    logic [NCH*MSG_WID-1:0] in_pkt_msg;
    logic                   out_pkt_vld;
    logic                   out_pkt_rdy;
    logic [DAT_WID-1:0]     out_pkt_dat;
    logic [OMSG_WID-1:0]    out_pkt_msg;
    logic                   cmd_err;
    logic [31:0]            stat_pkt_cnt;
    logic [31:0]            stat_drp_cnt;

    pkt_edit_mch #(
        .DAT_WID (DAT_WID),
        .MSG_WID (MSG_WID),
        .EOP_POS (EOP_POS),
        .NCH     (NCH),
        .ECMWID  (ECMWID)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_vld      (cmd_vld),
        .cmd_rdy      (cmd_rdy),
        .cmd_dat      (cmd_dat),
        .in_pkt_vld   (in_pkt_vld),
        .in_pkt_rdy   (in_pkt_rdy),
        .in_pkt_dat   (in_pkt_dat),
        .in_pkt_msg   (in_pkt_msg),
        .out_pkt_vld  (out_pkt_vld),
        .out_pkt_rdy  (out_pkt_rdy),
        .out_pkt_dat  (out_pkt_dat),
        .out_pkt_msg  (out_pkt_msg),
        .cmd_err      (cmd_err),
        .stat_pkt_cnt (stat_pkt_cnt),
        .stat_drp_cnt (stat_drp_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned err_cnt = 0;
    int unsigned exp_pkt = 0;
    int unsigned exp_drp = 0;
    logic        rnd_rdy = 1'b0;

    logic [255:0]        exp_dat_q[$];
    logic [OMSG_WID-1:0] exp_msg_q[$];
    logic [255:0]        obs_dat[$];
    logic [OMSG_WID-1:0] obs_msg[$];
    int unsigned         obs_cyc[$];
    int unsigned         in_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] beat_dat(input logic [3:0] ch, input logic [15:0] pkt, input logic [7:0] b);
        return {8{pkt, b, 4'h0, ch}};
    endfunction

    function automatic logic [MSG_WID-1:0] beat_msg(input logic [15:0] pkt, input logic [7:0] b, input logic eop);
        return {b[3:0], pkt[7:0], eop, 1'b0};
    endfunction

    // Expected output of one edited packet of len beats.
    task automatic expect_pkt(input logic [1:0] act, input logic [3:0] sn, input logic [3:0] ch,
                              input logic [7:0] tag, input logic [73:0] hdr,
                              input logic [15:0] pkt, input int unsigned len);
        int unsigned first;
        int unsigned idx;
        logic        eop_hdr;
        idx = 0;
        if (act == 2'b01) begin
            exp_drp++;
            return;
        end
        first = act[1] ? int'(sn) : 0;
        if (act == 2'b10 && first >= len) begin
            exp_drp++;
            return;
        end
        if (act == 2'b11) begin
            eop_hdr = (first >= len);
            exp_dat_q.push_back(256'(hdr));
            exp_msg_q.push_back({tag, 12'd0, ch, 12'd0, eop_hdr, 1'b0});
            idx = 1;
            if (eop_hdr) begin
                exp_pkt++;
                return;
            end
        end
        for (int unsigned b = first; b < len; b++) begin
            exp_dat_q.push_back(beat_dat(ch, pkt, 8'(b)));
            exp_msg_q.push_back({tag, 12'(idx), ch, beat_msg(pkt, 8'(b), b == len - 1)});
            idx++;
        end
        exp_pkt++;
    endtask

    task automatic set_ch(input int unsigned c, input logic v, input logic [255:0] d, input logic [MSG_WID-1:0] m);
        in_pkt_vld[c]                  = v;
        in_pkt_dat[c*DAT_WID +: DAT_WID] = d;
        in_pkt_msg[c*MSG_WID +: MSG_WID] = m;
    endtask

    // Called just after a rising edge.
    task automatic send_cmd(input logic [1:0] act, input logic [3:0] sn, input logic [3:0] ch,
                            input logic [7:0] tag, input logic [73:0] hdr);
        int unsigned n;
        cmd_dat = {hdr, tag, ch, sn, act};
        cmd_vld = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_rdy) check("cmd_timeout", 256'(1), 256'(0));
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic send_pkt(input int unsigned c, input logic [15:0] pkt, input int unsigned len);
        int unsigned n;
        logic [NCH-1:0] sel;
        sel = '0;
        sel[c] = 1'b1;
        for (int unsigned b = 0; b < len; b++) begin
            set_ch(c, 1'b1, beat_dat(4'(c), pkt, 8'(b)), beat_msg(pkt, 8'(b), b == len - 1));
            n = 0;
            @(negedge clk);
            while (!in_pkt_rdy[c] && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (!in_pkt_rdy[c]) check("in_rdy_timeout", 256'(1), 256'(0));
            check("rdy_other_ch", 256'(in_pkt_rdy & ~sel), 256'(0));
            in_cyc.push_back(cyc);
            @(posedge clk);
            #1;
        end
        set_ch(c, 1'b1, '1, '1);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (exp_dat_q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        if (exp_dat_q.size() != 0) check("drain_timeout", 256'(exp_dat_q.size()), 256'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        obs_dat.delete();
        obs_msg.delete();
        obs_cyc.delete();
        in_cyc.delete();
    endtask

    // Output monitor / scoreboard, plus output-hold check under backpressure.
    initial begin
        logic                prev_stall;
        logic [255:0]        prev_dat;
        logic [OMSG_WID-1:0] prev_msg;
        prev_stall = 1'b0;
        prev_dat   = '0;
        prev_msg   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_stall) begin
                    check("hold_vld", 256'(out_pkt_vld), 256'(1));
                    check("hold_dat", out_pkt_dat, prev_dat);
                    check("hold_msg", 256'(out_pkt_msg), 256'(prev_msg));
                end
                if (out_pkt_vld && out_pkt_rdy) begin
                    obs_dat.push_back(out_pkt_dat);
                    obs_msg.push_back(out_pkt_msg);
                    obs_cyc.push_back(cyc);
                    if (exp_dat_q.size() == 0) begin
                        check("unexpected_beat", 256'(1), 256'(0));
                    end else begin
                        check("out_dat", out_pkt_dat, exp_dat_q.pop_front());
                        check("out_msg", 256'(out_pkt_msg), 256'(exp_msg_q.pop_front()));
                    end
                end
                if (cmd_err) err_cnt++;
                prev_stall = out_pkt_vld & ~out_pkt_rdy;
                prev_dat   = out_pkt_dat;
                prev_msg   = out_pkt_msg;
            end
        end
    end

    initial begin
        out_pkt_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_pkt_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [1:0]  act;
        logic [3:0]  sn;
        int unsigned len;
        logic [73:0] hdr;

        rst        = 1'b1;
        cmd_vld    = 1'b0;
        cmd_dat    = '0;
        in_pkt_vld = '0;
        in_pkt_dat = '0;
        in_pkt_msg = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_rdy", 256'(cmd_rdy), 256'(0));
        check("rst_in_rdy", 256'(in_pkt_rdy), 256'(0));
        check("rst_out_vld", 256'(out_pkt_vld), 256'(0));
        check("rst_out_dat", out_pkt_dat, 256'(0));
        check("rst_out_msg", 256'(out_pkt_msg), 256'(0));
        check("rst_cmd_err", 256'(cmd_err), 256'(0));
        check("rst_stat_pkt", 256'(stat_pkt_cnt), 256'(0));
        check("rst_stat_drp", 256'(stat_drp_cnt), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) set_ch(c, 1'b1, '1, '1);

        // 1: pass, ch0, 3 beats: idx 0..2, EOP on last, one-cycle latency
        clear_logs();
        expect_pkt(2'b00, 4'd0, 4'd0, 8'h11, 74'd0, 16'd1, 3);
        send_cmd(2'b00, 4'd0, 4'd0, 8'h11, 74'd0);
        send_pkt(0, 16'd1, 3);
        drain();
        check("t1_nbeats", 256'(obs_msg.size()), 256'(3));
        if (obs_msg.size() == 3 && in_cyc.size() == 3) begin
            for (int unsigned k = 0; k < 3; k++) begin
                check("t1_beat_idx", 256'(obs_msg[k][29:18]), 256'(k));
                check("t1_eop", 256'(obs_msg[k][EOP_POS]), 256'(k == 2));
                check("t1_latency", 256'(obs_cyc[k]), 256'(in_cyc[k] + 1));
            end
        end

        // 2: strip 2 of 5 on ch2 -> original beats 3..5
        clear_logs();
        expect_pkt(2'b10, 4'd2, 4'd2, 8'h22, 74'd0, 16'd2, 5);
        send_cmd(2'b10, 4'd2, 4'd2, 8'h22, 74'd0);
        send_pkt(2, 16'd2, 5);
        drain();
        check("t2_nbeats", 256'(obs_msg.size()), 256'(3));
        if (obs_msg.size() == 3) begin
            check("t2_first_dat", obs_dat[0], {8{32'h0002_0202}});
            check("t2_ch", 256'(obs_msg[0][17:14]), 256'(2));
            check("t2_last_idx", 256'(obs_msg[2][29:18]), 256'(2));
        end

        // 3: strip 1 + header 0xABCD, tag 0x5A, ch1, 2 beats
        clear_logs();
        expect_pkt(2'b11, 4'd1, 4'd1, 8'h5a, 74'habcd, 16'd3, 2);
        send_cmd(2'b11, 4'd1, 4'd1, 8'h5a, 74'habcd);
        send_pkt(1, 16'd3, 2);
        drain();
        check("t3_nbeats", 256'(obs_msg.size()), 256'(2));
        if (obs_msg.size() == 2) begin
            check("t3_hdr_dat", obs_dat[0], 256'habcd);
            check("t3_hdr_msg", 256'(obs_msg[0]), 256'({8'h5a, 12'd0, 4'd1, 14'd0}));
            check("t3_dat", obs_dat[1], {8{32'h0003_0101}});
            check("t3_idx", 256'(obs_msg[1][29:18]), 256'(1));
            check("t3_eop", 256'(obs_msg[1][EOP_POS]), 256'(1));
        end

        // 4: strip 4 of a 2-beat packet, then a dropped packet -> no output
        clear_logs();
        expect_pkt(2'b10, 4'd4, 4'd3, 8'h44, 74'd0, 16'd4, 2);
        send_cmd(2'b10, 4'd4, 4'd3, 8'h44, 74'd0);
        send_pkt(3, 16'd4, 2);
        expect_pkt(2'b01, 4'd0, 4'd0, 8'h45, 74'd0, 16'd5, 3);
        send_cmd(2'b01, 4'd0, 4'd0, 8'h45, 74'd0);
        send_pkt(0, 16'd5, 3);
        drain();
        check("t4_nbeats", 256'(obs_msg.size()), 256'(0));
`ifdef PKT_EDIT_MCH_STAT_EN
        check("t4_stat_drp", 256'(stat_drp_cnt), 256'(2));
        check("t4_stat_pkt", 256'(stat_pkt_cnt), 256'(3));
`else
        check("t4_stat_drp", 256'(stat_drp_cnt), 256'(0));
        check("t4_stat_pkt", 256'(stat_pkt_cnt), 256'(0));
`endif

        // 5: ch=7 out of range -> cmd_err pulse, no channel touched
        clear_logs();
        send_cmd(2'b00, 4'd0, 4'd7, 8'h55, 74'd0);
        @(negedge clk);
        check("t5_err_hi", 256'(cmd_err), 256'(1));
        check("t5_in_rdy_a", 256'(in_pkt_rdy), 256'(0));
        @(negedge clk);
        check("t5_err_lo", 256'(cmd_err), 256'(0));
        check("t5_in_rdy_b", 256'(in_pkt_rdy), 256'(0));
        check("t5_cmd_rdy", 256'(cmd_rdy), 256'(1));
        @(posedge clk);
        #1;
        expect_pkt(2'b00, 4'd0, 4'd3, 8'h56, 74'd0, 16'd6, 1);
        send_cmd(2'b00, 4'd0, 4'd3, 8'h56, 74'd0);
        send_pkt(3, 16'd6, 1);
        drain();
        check("t5_next_cmd", 256'(obs_msg.size()), 256'(1));

        // 6: 100 mixed packets across 4 channels with random backpressure
        rnd_rdy = 1'b1;
        for (int unsigned i = 0; i < 100; i++) begin
            act = 2'($urandom_range(0, 3));
            sn  = 4'($urandom_range(0, 3));
            len = $urandom_range(1, 5);
            hdr = {42'd0, $urandom()};
            expect_pkt(act, sn, 4'(i % 4), 8'(i), hdr, 16'(100 + i), len);
            send_cmd(act, sn, 4'(i % 4), 8'(i), hdr);
            send_pkt(i % 4, 16'(100 + i), len);
        end
        drain();
        rnd_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t6_exp_left", 256'(exp_dat_q.size()), 256'(0));
`ifdef PKT_EDIT_MCH_STAT_EN
        check("t6_stat_pkt", 256'(stat_pkt_cnt), 256'(exp_pkt));
        check("t6_stat_drp", 256'(stat_drp_cnt), 256'(exp_drp));
`else
        check("t6_stat_pkt", 256'(stat_pkt_cnt), 256'(0));
        check("t6_stat_drp", 256'(stat_drp_cnt), 256'(0));
`endif
        check("err_pulse_total", 256'(err_cnt), 256'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
